// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl
// Description : Bit-serial adder/subtractor. Operands are captured on Start,
//               processed LSB first through one full-adder cell (one bit per
//               clock) and the result is published with a one-cycle Done.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic             Sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_ra;
    logic [WIDTH-1:0]   r_rb;
    logic [WIDTH-1:0]   r_rs;
    logic               r_c;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_s;
    logic               r_cout;

    // Full-adder cell: two half-adder stages, carries merged with an OR.
    logic             w_ha1_s;
    logic             w_ha1_c;
    logic             w_ha2_s;
    logic             w_ha2_c;
    logic             w_carry;
    logic [WIDTH-1:0] w_rs_next;

    assign w_ha1_s   = r_ra[0] ^ r_rb[0];
    assign w_ha1_c   = r_ra[0] & r_rb[0];
    assign w_ha2_s   = w_ha1_s ^ r_c;
    assign w_ha2_c   = w_ha1_s & r_c;
    assign w_carry   = w_ha1_c | w_ha2_c;
    // Sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
    assign w_rs_next = {w_ha2_s, r_rs[WIDTH-1:1]};

    // Control FSM plus datapath registers; outputs are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ra    <= '0;
            r_rb    <= '0;
            r_rs    <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_s     <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        // Subtraction is A + ~B + 1: invert B, seed carry with 1.
                        r_ra    <= A;
                        r_rb    <= Sub ? ~B : B;
                        r_c     <= Sub;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_ra  <= r_ra >> 1;
                    r_rb  <= r_rb >> 1;
                    r_rs  <= w_rs_next;
                    r_c   <= w_carry;
                    r_cnt <= r_cnt + c_cnt_w'(1);
                    if (r_cnt == c_last) begin
                        // Publish only the completed result, never partial bits.
                        r_s     <= w_rs_next;
                        r_cout  <= w_carry;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign Busy = r_busy;
    assign Done = r_done;
    assign S    = r_s;
    assign Cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_add_ctrl
// Description : Scoreboard bench for serial_add_ctrl (WIDTH=8). Stimulus
//               pushes expected results; a monitor pops them on each Done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             Start;
    logic             Sub;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] S;
    logic             Cout;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
    } exp_t;

    exp_t             q[$];
    int               n_cmp = 0;
    int               n_err = 0;
    logic [WIDTH-1:0] hold_s;
    logic             hold_c;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .Start (Start),
        .Sub   (Sub),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .Done  (Done),
        .S     (S),
        .Cout  (Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every Done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (Done === 1'b1) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got Done=1 with S=0x%0h expected no result", S);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result_S", 32'(S), 32'(e.s));
                chk("result_Cout", 32'(Cout), 32'(e.c));
            end
        end
    end

    // One operation: Start pulse, then check Busy/Done timing cycle by cycle.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sub,
                          input logic [7:0] es, input logic ec, input int glitch);
        @(negedge clk);
        A = a; B = b; Sub = sub; Start = 1'b1;
        q.push_back('{s: es, c: ec});
        for (int i = 1; i <= WIDTH + 1; i++) begin
            @(negedge clk);
            if (i <= WIDTH) begin
                chk("busy_run", 32'(Busy), 32'(1));
                chk("done_early", 32'(Done), 32'(0));
                chk("S_hold_run", 32'(S), 32'(hold_s));
                chk("Cout_hold_run", 32'(Cout), 32'(hold_c));
            end else begin
                chk("busy_done", 32'(Busy), 32'(0));
                chk("done_timing", 32'(Done), 32'(1));
            end
            if (i == 1) begin
                Start = 1'b0;
                A = 8'($urandom); B = 8'($urandom); Sub = 1'($urandom);
            end
            if (glitch > 0 && i == glitch) begin
                Start = 1'b1; A = 8'hAA; B = 8'h55; Sub = 1'b0;
            end else if (glitch > 0 && i == glitch + 1) begin
                Start = 1'b0;
            end
        end
        hold_s = es;
        hold_c = ec;
        @(negedge clk);
        chk("done_single", 32'(Done), 32'(0));
        chk("idle_busy", 32'(Busy), 32'(0));
        chk("S_hold_idle", 32'(S), 32'(hold_s));
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        rst = 1'b1; Start = 1'b1; Sub = 1'b0; A = 8'h11; B = 8'h22;
        hold_s = '0; hold_c = 1'b0;
        repeat (3) @(negedge clk);
        // Reset wins over Start asserted in the same cycle.
        chk("rst_busy", 32'(Busy), 32'(0));
        chk("rst_done", 32'(Done), 32'(0));
        chk("rst_S", 32'(S), 32'(0));
        chk("rst_Cout", 32'(Cout), 32'(0));
        rst = 1'b0; Start = 1'b0;
        @(negedge clk);
        chk("idle_no_start", 32'(Busy), 32'(0));

        run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
        run_op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 0);
        run_op(8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 0);
        run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 0);
        run_op(8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 0);
        run_op(8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 0);
        // Start pulsed in RUN cycle 3 with other operands is ignored.
        run_op(8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 3);

        // Reset in RUN cycle 4 aborts without a result.
        @(negedge clk);
        A = 8'h33; B = 8'h44; Sub = 1'b0; Start = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            Start = 1'b0;
            chk("busy_pre_abort", 32'(Busy), 32'(1));
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(Busy), 32'(0));
        chk("abort_done", 32'(Done), 32'(0));
        chk("abort_S", 32'(S), 32'(0));
        chk("abort_Cout", 32'(Cout), 32'(0));
        repeat (12) @(negedge clk);
        chk("abort_no_pending", 32'(q.size()), 32'(0));
        hold_s = '0; hold_c = 1'b0;
        run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 0);

        // Start held high: back-to-back operations every 10 cycles.
        @(negedge clk);
        A = 8'h01; B = 8'h01; Sub = 1'b0; Start = 1'b1;
        for (int k = 0; k < 3; k++) q.push_back('{s: 8'h02, c: 1'b0});
        for (int i = 1; i <= 29; i++) begin
            @(negedge clk);
            chk("held_done_cadence", 32'(Done), 32'((i == 9 || i == 19 || i == 29) ? 1 : 0));
            if (i == 29) Start = 1'b0;
        end
        repeat (4) @(negedge clk);
        chk("held_stopped", 32'(Busy), 32'(0));
        chk("final_pending", 32'(q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
